uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter CLK_FREQUENCY, default 25000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, payload width, legal range 5..9.
REQ-004 SHALL have parameter PARITY_MODE, default PARITY_NONE, one of NONE/ODD/EVEN.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-006 SHALL have port i_clock, input, 1, the single clock.
REQ-007 SHALL have port i_reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port i_valid, input, 1, upstream data-available flag.
REQ-009 SHALL have port i_data, input, DATA_BITS, byte to send.
REQ-010 SHALL have port o_ready, output, 1, block can accept a byte this cycle.
REQ-011 SHALL have port o_tx_serial, output, 1, serial line, idle high.
REQ-012 SHALL have port o_busy, output, 1, frame in progress.
REQ-013 SHALL have port o_tx_done, output, 1, one-cycle end-of-frame pulse.
REQ-014 SHALL have port o_current_state, output, 3, FSM state encoding from the package.

Function
REQ-015 CLKS_PER_BIT SHALL be CLK_FREQUENCY/BAUD_RATE (integer division); a value below 2 or an illegal parameter SHALL stop elaboration.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_MODE is NONE.
REQ-017 o_ready SHALL be high only in IDLE; o_busy SHALL equal not o_ready.
REQ-018 On a rising edge with i_valid and o_ready both high, i_data SHALL be latched and the FSM SHALL enter START.
REQ-019 o_tx_serial SHALL be low for the START bit, starting the cycle after acceptance.
REQ-020 Each bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-021 Data bits SHALL be sent LSB first, DATA_BITS bits.
REQ-022 The parity bit SHALL make the total count of ones (data plus parity) odd for ODD and even for EVEN.
REQ-023 STOP SHALL drive high for STOP_BITS bit periods.
REQ-024 On the edge ending the last stop-bit cycle, the FSM SHALL enter IDLE and o_tx_done SHALL be high for exactly that one IDLE cycle.
REQ-025 Total frame time SHALL be (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT cycles, where P is 1 with parity and 0 without.
REQ-026 A byte accepted in the o_tx_done cycle SHALL start its START bit on the next cycle, with no idle gap between frames.
REQ-027 i_data and i_valid changes while busy SHALL have no effect on the frame in progress.
REQ-028 The bit-period counter SHALL reset to 0 at every bit boundary; it SHALL NOT carry or wrap across bits.

Reset
REQ-029 While i_reset_n is low: state IDLE, o_tx_serial 1, o_ready 1, o_busy 0, o_tx_done 0, counters and latched data 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame at once, driving the line high with no partial stop bit.
REQ-031 After release, the first acceptance SHALL be possible on the first rising edge with i_reset_n high.

Structure
REQ-032 Package uart_pkg SHALL hold the state enum (3-bit) and the PARITY_NONE/ODD/EVEN constants.
REQ-033 Bit timing SHALL be a sub-module baud_tick_gen, parameterised by CLKS_PER_BIT, with a restart input and a one-cycle tick output.

Verification (CLK_FREQUENCY=4, BAUD_RATE=1, so CLKS_PER_BIT=4)
REQ-034 8N1, send 0xAB -> line 0,1,1,0,1,0,1,0,1,1, each held 4 cycles; o_tx_done 40 cycles after acceptance.
REQ-035 8E1 0xAB -> parity bit 1; 8O1 0xAB -> parity bit 0; frame length 44 cycles.
REQ-036 7O2 0x55 -> data 1,0,1,0,1,0,1, parity 1, two high stop bits; frame length 44 cycles.
REQ-037 Hold i_valid high for 0x12 then 0x34 -> second start bit immediately follows the o_tx_done cycle; both bytes decode correctly.
REQ-038 Assert i_reset_n low during DATA bit 3 -> line high and o_ready 1 in the same cycle; a new 0xAB then sends cleanly.
REQ-039 Loop 8N1 0xAB into the existing receiver -> receiver output 0xAB when o_tx_done pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Parity bit that makes data plus parity odd (ODD) or even (EVEN)
  function automatic logic parity_bit(input logic [8:0] data, input int unsigned mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Byte-stream handshake and line/status bundle of the UART transmitter.
interface uart_tx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                         i_valid;
  logic [DATA_BITS-1:0]         i_data;
  logic                         o_ready;
  logic                         o_tx_serial;
  logic                         o_busy;
  logic                         o_tx_done;
  logic [uart_pkg::STATE_W-1:0] o_current_state;

  modport master (
    output i_valid, i_data,
    input  o_ready, o_tx_serial, o_busy, o_tx_done, o_current_state
  );

  modport slave (
    input  i_valid, i_data,
    output o_ready, o_tx_serial, o_busy, o_tx_done, o_current_state
  );
endinterface

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module baud_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick_c
);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter restarts at every bit boundary, never carries into the next bit
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_c = (cnt_q == LAST);
endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_BITS LSB first, optional parity, 1-2 stop bits.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY = 25000000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned PARITY_MODE   = PARITY_NONE,
  parameter int unsigned STOP_BITS     = 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_valid,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_tx_serial,
  output logic                 o_busy,
  output logic                 o_tx_done,
  output logic [STATE_W-1:0]   o_current_state
);
  localparam int unsigned CLKS_PER_BIT = (BAUD_RATE == 0) ? 0 : CLK_FREQUENCY / BAUD_RATE;
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE > PARITY_EVEN ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
    $error("uart_tx_cfg: illegal parameter combination");
  end

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 restart_c;
  logic                 tick_c;

  assign restart_c = (state_q == ST_IDLE);

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (i_clock),
    .rst_n   (i_reset_n),
    .restart (restart_c),
    .tick_c  (tick_c)
  );

  // Next-state logic: the line value for the coming bit is decided at each tick
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    par_d      = par_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (i_valid) begin
          shift_d    = i_data;
          par_d      = parity_bit(9'(i_data), PARITY_MODE);
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          tx_d       = 1'b0;
          state_d    = ST_START;
        end
      end
      ST_START: if (tick_c) begin
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
        state_d = ST_DATA;
      end
      ST_DATA: if (tick_c) begin
        if (bit_idx_q == LAST_DATA) begin
          if (PARITY_MODE != PARITY_NONE) begin
            tx_d    = par_q;
            state_d = ST_PARITY;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end
        end else begin
          bit_idx_d = bit_idx_q + BIT_W'(1);
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
        end
      end
      ST_PARITY: if (tick_c) begin
        tx_d    = 1'b1;
        state_d = ST_STOP;
      end
      ST_STOP: if (tick_c) begin
        if (stop_idx_q == LAST_STOP) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          stop_idx_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = ~ready_d;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign o_ready         = ready_q;
  assign o_busy          = busy_q;
  assign o_tx_serial     = tx_q;
  assign o_tx_done       = done_q;
  assign o_current_state = state_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench: four frame formats (8N1, 8E1, 8O1, 7O2) at 4 clocks per bit.
module tb_uart_tx_cfg;
  import uart_pkg::*;

  localparam int unsigned CPB  = 4;
  localparam int unsigned NCFG = 4;
  localparam int unsigned NFR  = 20;

  typedef struct {
    logic [15:0] bits;
    longint      acc;
  } exp_t;

  logic   clk   = 1'b0;
  logic   rst_n = 1'b1;
  longint cyc   = 0;
  int     errs  = 0;
  int     checks = 0;
  bit     go    = 1'b0;
  bit     ph1 [NCFG];
  bit     fin [NCFG];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errs++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  function automatic bit all_set(input bit a [NCFG]);
    for (int i = 0; i < NCFG; i++) if (!a[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Reference frame from the line rules: start 0, data LSB first, parity, stop bits (1)
  function automatic logic [15:0] mk_frame(input int unsigned d, input int unsigned db,
                                           input int unsigned pm);
    logic [15:0] f;
    int unsigned ones, n;
    f = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < db; i++) begin
      f[1+i] = 1'((d >> i) & 1);
      ones += (d >> i) & 1;
    end
    n = 1 + db;
    if (pm != PARITY_NONE) f[n] = (pm == PARITY_ODD) ? 1'((ones % 2) == 0) : 1'(ones % 2);
    return f;
  endfunction

  function automatic logic [2:0] bit_state(input int unsigned pos, input int unsigned db,
                                           input int unsigned pm);
    if (pos == 0) return ST_START;
    if (pos <= db) return ST_DATA;
    if (pm != PARITY_NONE && pos == db + 1) return ST_PARITY;
    return ST_STOP;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int unsigned DB = (g == 3) ? 7 : 8;
    localparam int unsigned PM = (g == 0) ? PARITY_NONE : (g == 1) ? PARITY_EVEN : PARITY_ODD;
    localparam int unsigned SB = (g == 3) ? 2 : 1;
    localparam int unsigned NB = 1 + DB + ((PM != PARITY_NONE) ? 1 : 0) + SB;
    localparam int unsigned MASK = (1 << DB) - 1;

    uart_tx_cfg_if #(.DATA_BITS(DB)) u_if ();
    exp_t exp_q[$];

    uart_tx_cfg #(
      .CLK_FREQUENCY (4),
      .BAUD_RATE     (1),
      .DATA_BITS     (DB),
      .PARITY_MODE   (PM),
      .STOP_BITS     (SB)
    ) u_dut (
      .i_clock         (clk),
      .i_reset_n       (rst_n),
      .i_valid         (u_if.i_valid),
      .i_data          (u_if.i_data),
      .o_ready         (u_if.o_ready),
      .o_tx_serial     (u_if.o_tx_serial),
      .o_busy          (u_if.o_busy),
      .o_tx_done       (u_if.o_tx_done),
      .o_current_state (u_if.o_current_state)
    );

    // Driver: directed bytes, then random bytes with random gaps and junk while busy
    initial begin : drv
      int unsigned d, sent, gap, t;
      logic [6:0] snap;
      u_if.i_valid = 1'b0;
      u_if.i_data  = '0;
      repeat (2) @(negedge clk);
      snap = {u_if.o_tx_serial, u_if.o_ready, u_if.o_busy, u_if.o_tx_done, u_if.o_current_state};
      chk($sformatf("cfg%0d reset_state", g), snap, {4'b1100, ST_IDLE});
      for (t = 0; t < 200 && !rst_n; t++) #1;

      sent = 0;
      gap  = 0;
      t    = 0;
      while (sent < NFR && t < 20000) begin
        @(negedge clk);
        t++;
        if (u_if.o_ready) begin
          if (gap == 0) begin
            d = (sent == 0) ? ((DB == 7) ? 32'h55 : 32'hAB) :
                (sent == 1) ? 32'h12 : (sent == 2) ? 32'h34 : $urandom;
            d = d & MASK;
            u_if.i_valid = 1'b1;
            u_if.i_data  = DB'(d);
            exp_q.push_back('{mk_frame(d, DB, PM), cyc + 1});
            sent++;
            gap = (sent < 3 || $urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
          end else begin
            u_if.i_valid = 1'b0;
            u_if.i_data  = DB'($urandom);
            gap--;
          end
        end else begin
          u_if.i_data  = DB'($urandom);
          u_if.i_valid = (sent < 3) ? 1'b1 : 1'($urandom & 1);
        end
      end
      @(negedge clk);
      u_if.i_valid = 1'b0;
      for (t = 0; t < 400 && (exp_q.size() != 0 || u_if.o_busy); t++) @(negedge clk);
      if (t >= 400) timeout_fail($sformatf("cfg%0d drain1", g));
      ph1[g] = 1'b1;

      // Abort a frame with reset mid-data, then send cleanly right after release
      wait (go);
      @(negedge clk);
      u_if.i_valid = 1'b1;
      u_if.i_data  = DB'(32'hAB & MASK);
      exp_q.push_back('{mk_frame(32'hAB & MASK, DB, PM), cyc + 1});
      @(negedge clk);
      u_if.i_valid = 1'b0;
      for (t = 0; t < 400 && rst_n; t++) #1;
      #1;
      snap = {u_if.o_tx_serial, u_if.o_ready, u_if.o_busy, u_if.o_tx_done, u_if.o_current_state};
      chk($sformatf("cfg%0d midframe_reset", g), snap, {4'b1100, ST_IDLE});
      u_if.i_valid = 1'b1;
      u_if.i_data  = DB'(32'hAB & MASK);
      for (t = 0; t < 400 && !rst_n; t++) #1;
      exp_q.push_back('{mk_frame(32'hAB & MASK, DB, PM), cyc + 1});
      @(negedge clk);
      u_if.i_valid = 1'b0;
      for (t = 0; t < 400 && (exp_q.size() != 0 || u_if.o_busy); t++) @(negedge clk);
      if (t >= 400) timeout_fail($sformatf("cfg%0d drain2", g));
      fin[g] = 1'b1;
    end

    // Monitor: on each new frame pop the expectation and check every bit cycle
    initial begin : mon
      bit prev_busy, aborted;
      int bad;
      exp_t e;
      logic [6:0] snap;
      prev_busy = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          prev_busy = 1'b0;
          continue;
        end
        if (u_if.o_busy && !prev_busy) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("cfg%0d unexpected_frame", g), 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("cfg%0d start_cycle", g), cyc, e.acc);
            aborted = 1'b0;
            for (int b = 0; b < NB && !aborted; b++) begin
              bad = 0;
              for (int k = 0; k < CPB; k++) begin
                if (b != 0 || k != 0) @(negedge clk);
                if (!rst_n) begin
                  aborted = 1'b1;
                  break;
                end
                if (u_if.o_tx_serial !== e.bits[b] || u_if.o_tx_done !== 1'b0 ||
                    u_if.o_busy !== 1'b1 || u_if.o_current_state !== bit_state(b, DB, PM))
                  bad++;
              end
              if (!aborted)
                chk($sformatf("cfg%0d bit%0d(line %0b) bad_cycles", g, b, e.bits[b]), bad, 0);
            end
            if (!aborted) begin
              @(negedge clk);
              if (rst_n) begin
                snap = {u_if.o_tx_serial, u_if.o_ready, u_if.o_busy, u_if.o_tx_done,
                        u_if.o_current_state};
                chk($sformatf("cfg%0d done_cycle", g), snap, {4'b1101, ST_IDLE});
              end
            end
          end
        end
        prev_busy = u_if.o_busy;
      end
    end
  end

  initial begin : main
    int t;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    for (t = 0; t < 30000 && !all_set(ph1); t++) @(negedge clk);
    if (t >= 30000) timeout_fail("phase1");
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    // Accepted on the next edge; 18 cycles later the frame sits in data bit 3
    repeat (18) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    for (t = 0; t < 2000 && !all_set(fin); t++) @(negedge clk);
    if (t >= 2000) timeout_fail("phase2");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
